// File: rtl/newton_step_pkg.sv
// Shared types and constants for the Newton-Raphson refinement stage.
// Float field widths, bias and the 1.5 significand used by the SUB datapath.
package newton_step_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MUL1,
    S_WAIT1,
    S_MUL2,
    S_WAIT2,
    S_SUB,
    S_MUL3,
    S_WAIT3,
    S_DONE
  } state_e;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = 24;
  localparam int FP_BIAS = 127;
  localparam logic [SIG_W-1:0] THREE_HALVES_SIG = 24'hC00000;

endpackage

// File: rtl/newton_step_lzc24.sv
// Combinational 24-bit leading-zero counter.
// An all-zero input reports 24.
module lzc24 (
  input  logic [23:0] v_i,
  output logic [4:0]  lz_o
);

  always_comb begin
    lz_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v_i[i]) lz_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/newton_step.sv
// One Newton-Raphson step y1 = y0*(1.5 - (x/2)*y0*y0) on a shared multiplier.
// Define NEWTON_SECOND_ITER_EN to run a second refinement pass before done.
module newton_step
  import newton_step_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y0,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic [31:0] y_out,
  output logic        done,
  output logic        busy,
  output logic        sat
);

  localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MUL_LAT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   y0_q, y0_d;
  logic [31:0]   xh_q, xh_d;
  logic [31:0]   p_q, p_d;
  logic [31:0]   mula_q, mula_d;
  logic [31:0]   mulb_q, mulb_d;
  logic [31:0]   yout_q, yout_d;
  logic          sat_q, sat_d;
`ifdef NEWTON_SECOND_ITER_EN
  logic          pass_q, pass_d;
`endif

  logic [EXP_W-1:0] xe;
  logic [31:0]      xhalf;
  logic [EXP_W-1:0] pe;
  logic [MAN_W-1:0] pm;
  logic             p_sat;
  logic [EXP_W-1:0] shamt;
  logic [SIG_W-1:0] sig;
  logic [SIG_W-1:0] shifted;
  logic [SIG_W-1:0] diff;
  logic [SIG_W-1:0] norm;
  logic [4:0]       lz;
  logic [31:0]      t;

  assign xe    = (x[30:23] == '0) ? '0 : x[30:23] - 8'd1;
  assign xhalf = {1'b0, xe, x[22:0]};

  // 1.5 - p in fixed point; p < 1.5 is guaranteed on this path
  assign pe      = p_q[30:23];
  assign pm      = p_q[22:0];
  assign p_sat   = (pe > 8'(FP_BIAS)) ||
                   ((pe == 8'(FP_BIAS)) && (pm >= 23'h400000));
  assign shamt   = 8'(FP_BIAS) - pe;
  assign sig     = {1'b1, pm};
  assign shifted = (shamt >= 8'd24) ? '0 : (sig >> shamt);
  assign diff    = THREE_HALVES_SIG - shifted;
  assign norm    = diff << lz;
  assign t       = {1'b0, 8'(FP_BIAS) - {3'b000, lz}, norm[22:0]};

  lzc24 u_lzc (
    .v_i  (diff),
    .lz_o (lz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    y0_d    = y0_q;
    xh_d    = xh_q;
    p_d     = p_q;
    mula_d  = mula_q;
    mulb_d  = mulb_q;
    yout_d  = yout_q;
    sat_d   = sat_q;
`ifdef NEWTON_SECOND_ITER_EN
    pass_d  = pass_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          y0_d    = {1'b0, y0[30:0]};
          xh_d    = xhalf;
          mula_d  = {1'b0, y0[30:0]};
          mulb_d  = {1'b0, y0[30:0]};
          cnt_d   = LAT;
          state_d = S_WAIT1;
`ifdef NEWTON_SECOND_ITER_EN
          pass_d  = 1'b0;
`endif
        end
      end
      S_MUL1: begin
        mula_d  = y0_q;
        mulb_d  = y0_q;
        cnt_d   = LAT;
        state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (cnt_q == '0) begin
          mula_d  = xh_q;
          mulb_d  = mul_p;
          cnt_d   = LAT;
          state_d = S_WAIT2;
        end
      end
      S_WAIT2: begin
        if (cnt_q == '0) begin
          p_d     = mul_p;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (p_sat) begin
          sat_d   = 1'b1;
          yout_d  = '0;
          state_d = S_DONE;
        end else begin
          mula_d  = y0_q;
          mulb_d  = t;
          cnt_d   = LAT;
          state_d = S_WAIT3;
        end
      end
      S_WAIT3: begin
        if (cnt_q == '0) begin
`ifdef NEWTON_SECOND_ITER_EN
          if (!pass_q) begin
            pass_d  = 1'b1;
            y0_d    = {1'b0, mul_p[30:0]};
            state_d = S_MUL1;
          end else begin
            yout_d  = mul_p;
            sat_d   = 1'b0;
            state_d = S_DONE;
          end
`else
          yout_d  = mul_p;
          sat_d   = 1'b0;
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y0_q    <= '0;
      xh_q    <= '0;
      p_q     <= '0;
      mula_q  <= '0;
      mulb_q  <= '0;
      yout_q  <= '0;
      sat_q   <= 1'b0;
`ifdef NEWTON_SECOND_ITER_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y0_q    <= y0_d;
      xh_q    <= xh_d;
      p_q     <= p_d;
      mula_q  <= mula_d;
      mulb_q  <= mulb_d;
      yout_q  <= yout_d;
      sat_q   <= sat_d;
`ifdef NEWTON_SECOND_ITER_EN
      pass_q  <= pass_d;
`endif
    end
  end

  assign mul_a = mula_q;
  assign mul_b = mulb_q;
  assign y_out = yout_q;
  assign sat   = sat_q;
  assign done  = (state_q == S_DONE);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_newton_step.sv
// Bench for newton_step with a 3-stage truncating float multiplier model.
// A real-arithmetic reference predicts result, sat and done cycle per op.
module tb_newton_step;

  localparam int LAT = 3;
  localparam int L   = LAT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x, y0;
  logic [31:0] mul_a, mul_b, mul_p, y_out;
  logic        done, busy, sat;

  always #5 clk = ~clk;

  newton_step #(.MUL_LAT(LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y0    (y0),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .y_out (y_out),
    .done  (done),
    .busy  (busy),
    .sat   (sat)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // product of two singles is exact in double; r2f truncates to 24 bits
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  logic [31:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= fmul(mul_a, mul_b);
    s2 <= s1;
    s3 <= s2;
  end
  assign mul_p = s3;

  function automatic void ref_pass(input logic [31:0] xv, input logic [31:0] yv,
                                   output logic [31:0] ny, output bit s);
    real xr, pr, tr;
    logic [31:0] xh, p;
    xr = f2r({1'b0, xv[30:0]}) / 2.0;
    xh = r2f(xr);
    p  = fmul(xh, fmul(yv, yv));
    pr = f2r({1'b0, p[30:0]});
    if (pr >= 1.5) begin
      s  = 1'b1;
      ny = 32'd0;
    end else begin
      s  = 1'b0;
      tr = 1.5 - $floor(pr * 8388608.0) / 8388608.0;
      ny = fmul(yv, r2f(tr));
    end
  endfunction

  function automatic void ref_op(input logic [31:0] xv, input logic [31:0] yv,
                                 output logic [31:0] yo, output bit so, output int lo);
    logic [31:0] y1;
    bit s;
    ref_pass(xv, {1'b0, yv[30:0]}, y1, s);
    if (s) begin
      yo = 32'd0; so = 1'b1; lo = 2 * L + 1;
      return;
    end
`ifdef NEWTON_SECOND_ITER_EN
    begin
      logic [31:0] y2;
      ref_pass(xv, y1, y2, s);
      if (s) begin
        yo = 32'd0; so = 1'b1; lo = 3 * L + 2 + 2 * L + 1;
      end else begin
        yo = y2; so = 1'b0; lo = 6 * L + 3;
      end
    end
`else
    yo = y1; so = 1'b0; lo = 3 * L + 1;
`endif
  endfunction

  int          cyc = 0;
  int          t0 = 0, done_at = 0, lit_lat = 0;
  bit          act = 0, mz = 1, chk_en = 0, lit_on = 0;
  bit          pend_sat = 0, prev_sat = 0, lit_sat = 0;
  logic [31:0] pend_y = 0, prev_y = 0, lit_y = 0;
  int          checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h want %h", n, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit fin;
      fin = act && (cyc >= done_at);
      chk("done", 32'(done), 32'(act && (cyc == done_at)));
      chk("busy", 32'(busy), 32'(act && (cyc >= t0) && (cyc <= done_at)));
      chk("y_out", y_out, fin ? pend_y : prev_y);
      chk("sat", 32'(sat), 32'(fin ? pend_sat : prev_sat));
      if (mz) begin
        chk("mul_a_rst", mul_a, 32'd0);
        chk("mul_b_rst", mul_b, 32'd0);
      end
      if (lit_on && act && (cyc == done_at)) begin
        chk("lit_y", pend_y, lit_y);
        chk("lit_sat", 32'(pend_sat), 32'(lit_sat));
        chk("lit_lat", 32'(done_at - t0), 32'(lit_lat));
      end
    end
  end

  // drives start for edge T and arms the reference for that operation
  task automatic launch(input logic [31:0] xv, input logic [31:0] yv,
                        input bit lo_on, input logic [31:0] ly,
                        input bit ls, input int ll, output int lat);
    logic [31:0] ry;
    bit rs;
    start = 1'b1; x = xv; y0 = yv;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y0 = $urandom;
    if (act) begin
      prev_y = pend_y; prev_sat = pend_sat;
    end
    ref_op(xv, yv, ry, rs, lat);
    pend_y = ry; pend_sat = rs;
    t0 = cyc; done_at = cyc + lat;
    lit_on = lo_on; lit_y = ly; lit_sat = ls; lit_lat = ll;
    mz = 1'b0; act = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                        input bit lo_on, input logic [31:0] ly,
                        input bit ls, input int ll, input bit ign);
    int lat;
    launch(xv, yv, lo_on, ly, ls, ll, lat);
    for (int c = 1; c <= lat + 1; c++) begin
      if (ign && c == 5) begin
        start = 1'b1; x = 32'h40800000; y0 = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    rst = 1'b0; start = 1'b0; x = '0; y0 = '0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

`ifdef NEWTON_SECOND_ITER_EN
    run_op(32'h40800000, 32'h3F000000, 1, 32'h3F000000, 0, 27, 0);
    run_op(32'h3F800000, 32'h3F800000, 1, 32'h3F800000, 0, 27, 0);
    run_op(32'h3F800000, 32'h3F000000, 1, 32'h3F5E6800, 0, 27, 0);
    run_op(32'h40800000, 32'h3F800000, 1, 32'h00000000, 1, 9, 0);
    run_op(32'h00400000, 32'h3F800000, 1, 32'h40100000, 0, 27, 0);
    run_op(32'hC0800000, 32'hBF000000, 1, 32'h3F000000, 0, 27, 1);
`else
    run_op(32'h40800000, 32'h3F000000, 1, 32'h3F000000, 0, 13, 0);
    run_op(32'h3F800000, 32'h3F800000, 1, 32'h3F800000, 0, 13, 0);
    run_op(32'h3F800000, 32'h3F000000, 1, 32'h3F300000, 0, 13, 0);
    run_op(32'h40800000, 32'h3F800000, 1, 32'h00000000, 1, 9, 0);
    run_op(32'h00400000, 32'h3F800000, 1, 32'h3FC00000, 0, 13, 0);
    run_op(32'hC0800000, 32'hBF000000, 1, 32'h3F000000, 0, 13, 1);
`endif
    run_op(32'h41100000, 32'h3EA00000, 0, 32'h0, 0, 0, 0);

    // abort mid-operation: ignored start at T+5, reset sampled at T+6
    launch(32'h40800000, 32'h3F000000, 0, 32'h0, 0, 0, lat);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; x = 32'h40800000; y0 = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    act = 1'b0; prev_y = '0; prev_sat = 1'b0; mz = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

`ifdef NEWTON_SECOND_ITER_EN
    run_op(32'h40800000, 32'h3F000000, 1, 32'h3F000000, 0, 27, 0);
`else
    run_op(32'h40800000, 32'h3F000000, 1, 32'h3F000000, 0, 13, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/newton_step.md
# newton_step

Sequencer stage wrapped around the shared three-stage float `Multiplication` pipeline in the fast inverse square root datapath. Takes the magic-constant seed `y0` and the operand `x` and performs one Newton-Raphson refinement, `y1 = y0 * (1.5 - (x/2) * y0 * y0)`. It time-multiplexes the single multiplier through three products and performs the `1.5 - p` subtraction internally. It is both the producer of the multiplier's operands and the consumer of its result.

## Interface
- `MUL_LAT`, default 3: register stages in the attached multiplier, input to `NumOut`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `x` in 32: IEEE-754 single operand; sign ignored.
- `y0` in 32: seed estimate; sign ignored.
- `mul_a`, `mul_b` out 32: registered operands to the multiplier `Num_1`/`Num_2`.
- `mul_p` in 32: multiplier `NumOut`.
- `y_out` out 32: refined estimate; holds until the next completion.
- `done` out 1: one-cycle pulse, `y_out` valid.
- `busy` out 1: high in every state except IDLE.
- `sat` out 1: set with `done` when `p >= 1.5`.

## Operation
- **States:** IDLE, MUL1, WAIT1, MUL2, WAIT2, SUB, MUL3, WAIT3, DONE.
- **IDLE:**
  - On `start`, capture `x` and `y0`.
  - Drive `mul_a = mul_b = y0`.
  - Go to WAIT1.
  - Capture `xhalf = {0, x[30:23]-1, x[22:0]}`. If `x[30:23]==0`, the exponent field clamps to 0.
- **WAITn:**
  - A counter loads `MUL_LAT` at each operand launch and decrements once per cycle.
  - At count 0, the edge captures `mul_p`.
- **WAIT1 exit:** capture `y2 = mul_p`, launch `mul_a = xhalf`, `mul_b = mul_p` on the same edge, go to WAIT2.
- **WAIT2 exit:** register `p = mul_p`, go to SUB.
- **SUB:** compute `t = 1.5 - p` combinationally and register it at the SUB exit edge.
  - Sign bit of `p` is ignored.
  - If `p[30:23] > 127`, or `p[30:23]==127` and `p[22:0] >= 0x400000`: set `sat`, set `y_out = 0`, go to DONE. The multiplier cannot represent zero, so MUL3 is skipped.
  - Otherwise:
    - Shift significand `{1, p[22:0]}` right by `127 - p[30:23]`; a shift ≥ 24 gives 0. Truncate; no rounding.
    - Subtract from `0xC00000`, which is 1.5 as a 24-bit 1.23 value.
    - Normalise with a leading-zero count `lz`: exponent = `127 - lz`, mantissa = result `<< lz`, bits [22:0].
  - Launch `mul_a = y0`, `mul_b = t` and go to WAIT3.
- **WAIT3 exit:** `y_out <= mul_p`, `sat <= 0`, go to DONE.
- **DONE:** `done = 1` for exactly one cycle, then IDLE.
- **Busy behaviour:** `start` is ignored while `busy`. `x`/`y0` may change after the start edge without effect.
- **Mid-operation reset:** any cycle with `rst == 0` forces IDLE. The in-flight result is discarded; no `done` is issued.

## Timing
- **Reset values:** `mul_a`, `mul_b`, `y_out` = 0; `done`, `busy`, `sat` = 0.
- **Start edge:** call it T. `busy` is high from T onward.
- **Multiply turnaround:** each multiply takes `MUL_LAT+1` cycles, launch edge to capture edge.
- **Normal path:**
  - SUB occupies one cycle.
  - Final capture at T+3(`MUL_LAT`+1)+1, which is T+13 for the default.
  - `done` is high in the cycle after that edge.
- **Saturated path:** `done` is high in the cycle after edge T+2(`MUL_LAT`+1)+1, which is T+9.
- **Back-to-back:** the earliest next accepted `start` is the cycle after DONE.

## Configuration
- `NEWTON_SECOND_ITER_EN` defined:
  - After WAIT3, `y0` is replaced by the captured product and the sequence reruns from MUL1 with the same `x`.
  - `done` is issued only after the second pass; default latency is 26 + 1 cycles of state overhead.
  - `sat` from either pass ends the operation immediately.
- Undefined: exactly one iteration, as above.

## Structure
- A shared package holds:
  - The state enum.
  - `FP_BIAS = 127`.
  - `THREE_HALVES_SIG = 24'hC00000`.
  - The float field slice widths.
- One natural sub-module: `lzc24`, a combinational 24-bit leading-zero counter with 5-bit output, used in SUB.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Bench pairs the block with a 3-cycle behavioural multiplier matching the truncating product.
- `x`=0x40800000 (4.0), `y0`=0x3F000000 (0.5) -> `y_out`=0x3F000000, `sat`=0, `done` at T+13 only.
- `x`=0x3F800000, `y0`=0x3F800000 -> `t`=1.0, `y_out`=0x3F800000.
- `x`=0x3F800000, `y0`=0x3F000000 -> `p`=0x3E000000, `t`=0x3FB00000, `y_out`=0x3F300000.
- `x`=0x40800000, `y0`=0x3F800000 -> `p`=2.0, `sat`=1, `y_out`=0, `done` at T+9.
- `start` pulsed again at T+5 is ignored. `rst` low at T+6 -> all outputs 0, no `done`. A fresh `start` after reset completes normally at +13.
- With `NEWTON_SECOND_ITER_EN`: `x`=0x3F800000, `y0`=0x3F000000 -> second pass seeded with 0x3F300000. `done` only once, after the second pass.
